// File: rtl/booth_seq_mult.sv
// Iterative radix-2 Booth multiplier.
// One shared (W+1)-bit ripple add/subtract chain of full adders performs one
// Booth step per clock. A complete multiply takes W RUN cycles plus one DONE
// cycle, so one result is produced every W+2 cycles.
//
// Handshake: a request is accepted on a rising edge where o_ready=1 and
// i_start=1; the operands are captured on that same edge. o_ready is high only
// in IDLE, so i_start is ignored (not queued) while a multiply is in flight.
// o_done pulses for exactly one cycle when o_product is updated, and
// o_product then holds its value until the next o_done.

// Single-bit full adder: the cell the shared add/subtract chain is built from.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    // Sum and carry of three input bits.
    always_comb begin
        s_o = a_i ^ b_i ^ c_i;
        c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    end
endmodule

module booth_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [WIDTH-1:0]       i_multiplicand,
    input  logic [WIDTH-1:0]       i_multiplier,
    output logic                   o_ready,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [2*WIDTH-1:0]     o_product,
    output logic [1:0]             o_state
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;      // partial-product accumulator, W+1 bits
    logic [WIDTH:0]       m_q, m_d;      // sign-extended multiplicand
    logic [WIDTH-1:0]     q_q, q_d;      // multiplier, shifted out LSB first
    logic                 qm1_q, qm1_d;  // Booth q(-1) bit
    logic [CNT_W-1:0]     cnt_q, cnt_d;  // completed Booth steps
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    // Booth decode of the current multiplier pair {Q[0], q_m1}.
    logic                 do_add;
    logic                 do_sub;
    assign do_add = ~q_q[0] &  qm1_q;
    assign do_sub =  q_q[0] & ~qm1_q;

    // Shared ripple chain: subtraction is A + ~M with carry-in 1.
    logic [WIDTH:0]       add_b;
    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       carry;
    logic                 cout_unused;   // top carry-out is discarded by design

    assign add_b    = do_sub ? ~m_q : m_q;
    assign carry[0] = do_sub;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_chain
        if (i < WIDTH) begin : g_mid
            full_adder u_fa (
                .a_i (a_q[i]),
                .b_i (add_b[i]),
                .c_i (carry[i]),
                .s_o (add_sum[i]),
                .c_o (carry[i+1])
            );
        end else begin : g_top
            full_adder u_fa (
                .a_i (a_q[i]),
                .b_i (add_b[i]),
                .c_i (carry[i]),
                .s_o (add_sum[i]),
                .c_o (cout_unused)
            );
        end
    end

    // A after the optional add/subtract, before the shift.
    logic [WIDTH:0]       a_step;
    assign a_step = (do_add | do_sub) ? add_sum : a_q;

    // State and datapath registers; reset abandons any multiply in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    // Next-state and datapath update: load in IDLE, one Booth step per RUN edge.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    m_d     = {i_multiplicand[WIDTH-1], i_multiplicand};
                    a_d     = '0;
                    q_d     = i_multiplier;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Arithmetic shift right of {A', Q, q_m1}; A's MSB is replicated.
                a_d   = {a_step[WIDTH], a_step[WIDTH:1]};
                q_d   = {a_step[0], q_q[WIDTH-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    prod_d  = {a_d[WIDTH-1:0], q_d};
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded from registered state only.
    always_comb begin
        o_ready   = (state_q == S_IDLE);
        o_busy    = (state_q == S_RUN);
        o_done    = (state_q == S_DONE);
        o_product = prod_q;
        o_state   = state_q;
    end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Testbench for booth_seq_mult (W=8): directed and random multiplies checked
// against a plain signed-multiply reference through an expected-result queue.
module tb_booth_seq_mult;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [W-1:0]     mcand = '0;
  logic [W-1:0]     mplier = '0;
  logic             ready;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  booth_seq_mult #(.WIDTH(W)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_multiplicand (mcand),
    .i_multiplier   (mplier),
    .o_ready        (ready),
    .o_busy         (busy),
    .o_done         (done),
    .o_product      (product),
    .o_state        (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];
  int             acc_q[$];
  int             n_checks = 0;
  int             n_errors = 0;
  logic           chk_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: exact signed product of two W-bit operands.
  function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] m, input logic [W-1:0] q);
    longint pm;
    longint pq;
    longint p;
    pm = longint'($signed(m));
    pq = longint'($signed(q));
    p  = pm * pq;
    return p[2*W-1:0];
  endfunction

  // Monitor: compares every o_done against the oldest expectation.
  always @(negedge clk) begin
    if (rst) begin
      chk_ready = 1'b0;
    end else begin
      if (chk_ready) begin
        check("ready_after_done", {63'd0, ready}, 64'd1);
        check("done_single_pulse", {63'd0, done}, 64'd0);
        chk_ready = 1'b0;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          logic [2*W-1:0] e;
          int             a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("product", {48'd0, product}, {48'd0, e});
          check("latency", 64'(cyc - a), 64'(W));
        end
        chk_ready = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one multiply: wait for ready (bounded), drive for one edge, record.
  task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q);
    int k;
    k = 0;
    while (!ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!ready) begin
      check("ready_timeout", 64'd0, 64'd1);
    end else begin
      mcand  = m;
      mplier = q;
      start  = 1'b1;
      exp_q.push_back(ref_mult(m, q));
      acc_q.push_back(cyc + 1);
      @(negedge clk);
      start  = 1'b0;
    end
  endtask

  // Wait until all expected results have been seen (bounded).
  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      acc_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] corner_vals [4];

  initial begin
    corner_vals[0] = 8'h80;
    corner_vals[1] = 8'h7F;
    corner_vals[2] = 8'h00;
    corner_vals[3] = 8'hFF;

    // Reset values
    #3;
    check("rst_ready",   {63'd0, ready},   64'd1);
    check("rst_busy",    {63'd0, busy},    64'd0);
    check("rst_done",    {63'd0, done},    64'd0);
    check("rst_product", {48'd0, product}, 64'd0);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(1);

    // Basic and directed cases
    do_op(8'd3, 8'd5);
    check("busy_in_run", {63'd0, busy},  64'd1);
    check("ready_in_run", {63'd0, ready}, 64'd0);
    drain();
    check("product_3x5", {48'd0, product}, 64'h000F);
    do_op(8'hF9, 8'd6);   drain();
    check("product_m7x6", {48'd0, product}, 64'hFFD6);
    do_op(8'd6, 8'hF9);   drain();
    do_op(8'h80, 8'h80);  drain();
    check("product_min_min", {48'd0, product}, 64'h4000);
    do_op(8'h7F, 8'h80);  drain();
    check("product_max_min", {48'd0, product}, 64'hC080);
    do_op(8'h00, 8'hFF);  drain();

    // Starts during RUN and DONE are ignored
    do_op(8'd3, 8'd5);
    wait_cycles(2);
    mcand = 8'd9; mplier = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int k;
      k = 0;
      while (!done && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("done_seen", {63'd0, done}, 64'd1);
    end
    mcand = 8'd9; mplier = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cycles(W + 4);
    check("ignored_start_product", {48'd0, product}, 64'h000F);
    check("ignored_start_idle", {63'd0, ready}, 64'd1);

    // Asynchronous reset in the middle of RUN
    do_op(8'd3, 8'd5);
    wait_cycles(3);
    #2;
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    #1;
    check("arst_ready",   {63'd0, ready},   64'd1);
    check("arst_busy",    {63'd0, busy},    64'd0);
    check("arst_done",    {63'd0, done},    64'd0);
    check("arst_product", {48'd0, product}, 64'd0);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(W + 4);
    do_op(8'd2, 8'd2);    drain();
    check("product_2x2", {48'd0, product}, 64'h0004);

    // Back-to-back with i_start held high and random operands
    begin
      int n;
      int prev_acc;
      n = 0;
      prev_acc = -1;
      for (int k = 0; k < 20000 && n < 1000; k++) begin
        logic [W-1:0] m;
        logic [W-1:0] q;
        m = W'($urandom);
        q = W'($urandom);
        if ($urandom_range(0, 7) == 0) m = corner_vals[$urandom_range(0, 3)];
        if ($urandom_range(0, 7) == 0) q = corner_vals[$urandom_range(0, 3)];
        mcand  = m;
        mplier = q;
        start  = 1'b1;
        if (ready) begin
          exp_q.push_back(ref_mult(m, q));
          acc_q.push_back(cyc + 1);
          if (prev_acc >= 0) check("accept_spacing", 64'(cyc + 1 - prev_acc), 64'(W + 2));
          prev_acc = cyc + 1;
          n++;
        end
        @(negedge clk);
      end
      start = 1'b0;
      check("b2b_op_count", 64'(n), 64'd1000);
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/booth_seq_mult.md
Name: booth_seq_mult

Overview:
- Iterative radix-2 Booth multiplier controller.
- Sequences one shared (W+1)-bit ripple add/subtract datapath built from full_adder instances, one Booth step per clock, over W cycles.
- Sits beside the combinational Booth array as the low-area multiply option.
- Single start/ready/done handshake toward the requester.

Parameters:
- WIDTH, 8: operand width W in bits. Operands are signed two's complement. Legal for W >= 2.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  request a multiply. Sampled only when o_ready=1.
- i_multiplicand  in  W  signed operand M. Captured on the accepting edge.
- i_multiplier  in  W  signed operand Q. Captured on the accepting edge.
- o_ready  out  1  high in IDLE only.
- o_busy  out  1  high in RUN.
- o_done  out  1  one-cycle pulse when o_product is updated.
- o_product  out  2W  signed product. Held until the next o_done.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE and the iteration counter clears to 0.
  - o_ready=1, o_busy=0, o_done=0.
  - o_product=0; internal A, Q, q_m1 and M all clear to 0.
  - A reset mid-RUN abandons the operation; no o_done is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on an edge with i_start=1:
    - M <= sign-extend(i_multiplicand) to W+1 bits.
    - A <= 0 (W+1 bits); Q <= i_multiplier; q_m1 <= 0; count <= 0.
    - Go to RUN.
    - With i_start=0, stay in IDLE.
  - RUN: one Booth step per edge.
    - {Q[0], q_m1} = 01: A <= A + M.
    - {Q[0], q_m1} = 10: A <= A - M, computed as A + ~M with carry-in 1 through the same adder chain.
    - {Q[0], q_m1} = 00 or 11: A is unchanged.
    - Then arithmetic-shift {A', Q, q_m1} right by 1 in the same edge (A' = A after the add/subtract). A's MSB is replicated.
    - count increments each step.
    - On the edge completing step W (count = W-1), load o_product <= {A'[W-1:0], Q'} (the post-shift values) and go to DONE.
  - DONE: o_done=1 for exactly this cycle. The next edge returns to IDLE unconditionally.
- Latency: start accepted at edge 0 → o_done high during the cycle following edge W. The next start can be accepted at edge W+2 (the first IDLE edge). Throughput is one result per W+2 cycles.
- i_start while o_ready=0 (RUN or DONE) is ignored: not queued, no effect on the operation in flight.
- Operand inputs are don't-care except on the accepting edge.
- Width rules:
  - A and M are W+1 bits, so A - M cannot overflow when M = -2^(W-1).
  - All adder carry-outs are discarded.
  - The product is exact for every operand pair, including the most-negative × most-negative case.
- o_ready and o_busy are decoded from state (registered state, no combinational path from i_start).
- o_done is high only in DONE.

Test Plan:
- W=8: reset, then start with M=3, Q=5 → o_done exactly 8 cycles after the accepting edge, o_product=0x000F, o_ready back to 1 one cycle later.
- W=8: M=-7 (0xF9), Q=6 → o_product=0xFFD6 (-42). M=6, Q=-7 → same result.
- W=8 corner cases:
  - M=-128, Q=-128 → 0x4000.
  - M=127, Q=-128 → 0xC080.
  - M=0, Q=-1 → 0x0000.
- Start with 3×5; pulse i_start with M=9, Q=9 at RUN cycle 3 and again in DONE → only 0x000F produced, a single o_done, product held afterwards.
- Assert i_rst asynchronously (between edges) at RUN cycle 4 → all outputs return to their reset values immediately and no o_done follows. After release, 2×2 → 0x0004.
- Back-to-back: hold i_start=1 continuously with randomized operands over 1000 ops → every product matches the signed reference model, and accepting edges are exactly W+2 cycles apart.
